// File: rtl/vip_frame_sequencer.sv
// Frame sequencer for the VIP pixel pipeline: generates CMOS-style source timing
// and read addresses, then tracks the processed stream to produce result-buffer writes.
module vip_frame_sequencer #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_SYNC    = 5,
    parameter int H_BACK    = 5,
    parameter int H_FRONT   = 5,
    parameter int V_SYNC    = 1,
    parameter int V_BACK    = 0,
    parameter int V_FRONT   = 1,
    parameter int HDR_BYTES = 54,
    parameter int BPP       = 3,
    parameter int CLKEN_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    output logic        busy,
    output logic        pix_rd_en,
    output logic [31:0] pix_rd_addr,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic        cmos_clken,
    input  logic        post_vsync,
    input  logic        post_href,
    input  logic        post_clken,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        size_err,
    output logic        overflow
);

    localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_START  = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] H_END    = 16'(H_SYNC + H_BACK + IMG_HDISP);
    localparam logic [15:0] V_START  = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] V_END    = 16'(V_SYNC + V_BACK + IMG_VDISP);
    localparam logic [15:0] V_SYNC_L = 16'(V_SYNC);
    localparam logic [3:0]  PH_LAST  = 4'(CLKEN_DIV - 1);
    localparam logic [31:0] NPIX     = 32'(IMG_HDISP * IMG_VDISP);
    localparam logic [31:0] HDR      = 32'(HDR_BYTES);
    localparam logic [31:0] BPP_L    = 32'(BPP);
    localparam logic [31:0] HDISP_L  = 32'(IMG_HDISP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  phase;
    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic        run;
    logic        tick;
    logic        eof;
    logic        in_win;
    logic [31:0] x;
    logic [31:0] y;
    logic        href_r;
    logic        tick_r;

    logic        pix_ev;
    logic        vs_q;
    logic        closing;
    logic [31:0] pix_cnt;
    logic [31:0] cnt_eff;

    assign run    = (state == RUN);
    assign busy   = (state != IDLE);
    assign tick   = run && (phase == PH_LAST);
    assign eof    = tick && (hcnt == H_LAST) && (vcnt == V_LAST);
    assign in_win = run && (vcnt >= V_START) && (vcnt < V_END)
                        && (hcnt >= H_START) && (hcnt < H_END);
    assign x      = {16'd0, hcnt} - {16'd0, H_START};
    assign y      = {16'd0, vcnt} - {16'd0, V_START};

    // A pixel arriving in the same cycle as the closing vsync edge belongs to the closing frame.
    assign pix_ev  = busy && post_href && post_clken;
    assign wr_en   = pix_ev && (pix_cnt < NPIX);
    assign cnt_eff = pix_cnt + {31'd0, pix_ev};
    assign closing = busy && vs_q && !post_vsync && (cnt_eff != 32'd0);

    always_comb begin
        // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (eof && !continuous) state_nxt = DRAIN;
            DRAIN:   if (closing) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 4'd0;
            hcnt  <= 16'd0;
            vcnt  <= 16'd0;
        end else if (state == IDLE && start) begin
            phase <= 4'd0;
            hcnt  <= 16'd0;
            vcnt  <= 16'd0;
        end else if (run) begin
            if (tick) begin
                phase <= 4'd0;
                if (hcnt == H_LAST) begin
                    hcnt <= 16'd0;
                    vcnt <= (vcnt == V_LAST) ? 16'd0 : vcnt + 16'd1;
                end else begin
                    hcnt <= hcnt + 16'd1;
                end
            end else begin
                phase <= phase + 4'd1;
            end
        end else begin
            phase <= 4'd0;
        end
    end

    // href/clken trail the read request by one extra cycle to line up with memory read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_rd_en   <= 1'b0;
            pix_rd_addr <= 32'd0;
            cmos_vsync  <= 1'b0;
            href_r      <= 1'b0;
            tick_r      <= 1'b0;
            cmos_href   <= 1'b0;
            cmos_clken  <= 1'b0;
        end else begin
            pix_rd_en   <= in_win;
            pix_rd_addr <= in_win ? HDR + (y * HDISP_L + x) * BPP_L : 32'd0;
            cmos_vsync  <= run && (vcnt >= V_SYNC_L);
            href_r      <= in_win;
            tick_r      <= tick;
            cmos_href   <= href_r;
            cmos_clken  <= href_r && tick_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vs_q       <= 1'b0;
            pix_cnt    <= 32'd0;
            wr_addr    <= HDR;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            size_err   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            vs_q       <= post_vsync;
            frame_done <= closing;
            if (pix_ev && !wr_en) overflow <= 1'b1;
            if (closing) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (cnt_eff != NPIX) size_err <= 1'b1;
                pix_cnt   <= 32'd0;
                wr_addr   <= HDR;
            end else begin
                if (pix_ev) pix_cnt <= cnt_eff;
                if (wr_en)  wr_addr <= wr_addr + BPP_L;
            end
        end
    end

endmodule

// File: tb/tb_vip_frame_sequencer.sv
// Directed bench for vip_frame_sequencer on a 4x2 frame with the pipeline looped
// back through a fixed delay, plus hand-driven output streams for error cases.
module tb_vip_frame_sequencer;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        busy;
    logic        pix_rd_en;
    logic [31:0] pix_rd_addr;
    logic        cmos_vsync;
    logic        cmos_href;
    logic        cmos_clken;
    logic        post_vsync;
    logic        post_href;
    logic        post_clken;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        size_err;
    logic        overflow;

    logic           lb_en = 1'b1;
    logic           man_vs = 1'b0;
    logic           man_hr = 1'b0;
    logic           man_ck = 1'b0;
    logic [LAT-1:0] dly_vs = '0;
    logic [LAT-1:0] dly_hr = '0;
    logic [LAT-1:0] dly_ck = '0;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    int          n_clken = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_done = 0;
    logic [31:0] wr_log [0:255];
    logic [31:0] rd_log [0:255];
    logic        prev_rd_en = 1'b0;
    logic [31:0] prev_rd_addr = 32'd0;

    always #5 clk = ~clk;

    vip_frame_sequencer #(
        .IMG_HDISP(4), .IMG_VDISP(2),
        .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(0), .V_FRONT(1),
        .HDR_BYTES(54), .BPP(3), .CLKEN_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .busy(busy),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr),
        .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_clken(cmos_clken),
        .post_vsync(post_vsync), .post_href(post_href), .post_clken(post_clken),
        .wr_en(wr_en), .wr_addr(wr_addr), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .size_err(size_err), .overflow(overflow)
    );

    // Stand-in pipeline: fixed-latency delay from the source timing back to the post side.
    always @(posedge clk) begin
        dly_vs <= {dly_vs[LAT-2:0], cmos_vsync};
        dly_hr <= {dly_hr[LAT-2:0], cmos_href};
        dly_ck <= {dly_ck[LAT-2:0], cmos_clken};
    end

    assign post_vsync = lb_en ? dly_vs[LAT-1] : man_vs;
    assign post_href  = lb_en ? dly_hr[LAT-1] : man_hr;
    assign post_clken = lb_en ? dly_ck[LAT-1] : man_ck;

    always @(negedge clk) begin
        if (cmos_clken) n_clken <= n_clken + 1;
        if (frame_done) n_done <= n_done + 1;
        if (wr_en) begin
            if (n_wr < 256) wr_log[n_wr] <= wr_addr;
            n_wr <= n_wr + 1;
        end
        if (pix_rd_en && (!prev_rd_en || pix_rd_addr != prev_rd_addr)) begin
            if (n_rd < 256) rd_log[n_rd] <= pix_rd_addr;
            n_rd <= n_rd + 1;
        end
        prev_rd_en   <= pix_rd_en;
        prev_rd_addr <= pix_rd_addr;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Waits for the next frame_done; cyc = -1 on timeout, busy_at_done = busy in that cycle.
    task automatic wait_done(input int budget, output int cyc, output logic busy_at_done);
        cyc = -1;
        busy_at_done = 1'bx;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (frame_done) begin
                cyc = i;
                busy_at_done = busy;
                break;
            end
        end
        idle_cycles(3);
    endtask

    task automatic drive_manual_frame(input int npix);
        @(posedge clk); #1 man_vs = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < npix; i++) begin
            man_hr = 1'b1; man_ck = 1'b1;
            @(posedge clk); #1 man_ck = 1'b0;
            @(posedge clk); #1;
        end
        man_hr = 1'b0;
        @(posedge clk); #1 man_vs = 1'b0;
    endtask

    task automatic test_reset();
        idle_cycles(2);
        checks++;
        if ({busy, pix_rd_en, cmos_vsync, cmos_href, cmos_clken, wr_en, frame_done, size_err, overflow} !== 9'd0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000000",
                     {busy, pix_rd_en, cmos_vsync, cmos_href, cmos_clken, wr_en, frame_done, size_err, overflow});
        end
        checks++;
        if (pix_rd_addr !== 32'd0) begin errors++; $display("FAIL reset_rd_addr got %0d expected 0", pix_rd_addr); end
        checks++;
        if (wr_addr !== 32'd54) begin errors++; $display("FAIL reset_wr_addr got %0d expected 54", wr_addr); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d expected 0", frame_cnt); end
        @(negedge clk) rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_single_frame();
        int cb, wb, rb, cyc;
        logic bd;
        cb = n_clken; wb = n_wr; rb = n_rd;
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_start got %b expected 1", busy); end
        wait_done(300, cyc, bd);
        exp_frames++;
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL single_done_timeout got none expected frame_done"); end
        checks++;
        if (bd !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got %b expected 0", bd); end
        checks++;
        if (n_clken - cb != 8) begin errors++; $display("FAIL single_clken_count got %0d expected 8", n_clken - cb); end
        checks++;
        if (n_rd - rb != 8) begin errors++; $display("FAIL single_rd_count got %0d expected 8", n_rd - rb); end
        checks++;
        if (n_wr - wb != 8) begin errors++; $display("FAIL single_wr_count got %0d expected 8", n_wr - wb); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_log[rb + i] !== 32'(54 + 3 * i)) begin
                errors++; $display("FAIL single_rd_addr[%0d] got %0d expected %0d", i, rd_log[rb + i], 54 + 3 * i);
            end
            checks++;
            if (wr_log[wb + i] !== 32'(54 + 3 * i)) begin
                errors++; $display("FAIL single_wr_addr[%0d] got %0d expected %0d", i, wr_log[wb + i], 54 + 3 * i);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL single_frame_cnt got %0d expected %0d", frame_cnt, exp_frames); end
        checks++;
        if ({busy, size_err, overflow} !== 3'b000) begin
            errors++; $display("FAIL single_status got busy/size_err/overflow=%b expected 000", {busy, size_err, overflow});
        end
        checks++;
        if (wr_addr !== 32'd54) begin errors++; $display("FAIL single_wr_addr_rewind got %0d expected 54", wr_addr); end
    endtask

    task automatic test_continuous();
        int cb, wb, cyc, seen, busy_low;
        int t_done [3];
        logic bd3;
        cb = n_clken; wb = n_wr;
        seen = 0; busy_low = 0; cyc = 0; bd3 = 1'bx;
        continuous = 1'b1;
        pulse_start();
        while (seen < 3 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (frame_done) begin
                t_done[seen] = cyc;
                if (seen == 2) bd3 = busy;
                seen++;
            end else if (!busy) begin
                busy_low++;
            end
            if (seen == 2 && continuous && cyc >= t_done[1] + 10) continuous = 1'b0;
        end
        continuous = 1'b0;
        exp_frames += 3;
        idle_cycles(3);
        checks++;
        if (seen != 3) begin errors++; $display("FAIL cont_done_count got %0d expected 3", seen); end
        checks++;
        if (busy_low != 0) begin errors++; $display("FAIL cont_idle_gap got %0d idle cycles expected 0", busy_low); end
        if (seen == 3) begin
            checks++;
            if (t_done[1] - t_done[0] != 56) begin
                errors++; $display("FAIL cont_period_1 got %0d expected 56", t_done[1] - t_done[0]);
            end
            checks++;
            if (t_done[2] - t_done[1] != 56) begin
                errors++; $display("FAIL cont_period_2 got %0d expected 56", t_done[2] - t_done[1]);
            end
            checks++;
            if (bd3 !== 1'b0) begin errors++; $display("FAIL cont_busy_at_last_done got %b expected 0", bd3); end
        end
        checks++;
        if (n_clken - cb != 24) begin errors++; $display("FAIL cont_clken_count got %0d expected 24", n_clken - cb); end
        checks++;
        if (n_wr - wb != 24) begin errors++; $display("FAIL cont_wr_count got %0d expected 24", n_wr - wb); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL cont_frame_cnt got %0d expected %0d", frame_cnt, exp_frames); end
        idle_cycles(80);
        checks++;
        if ({busy, size_err} !== 2'b00) begin
            errors++; $display("FAIL cont_after_status got busy/size_err=%b expected 00", {busy, size_err});
        end
    endtask

    task automatic test_start_ignored();
        int db, cyc;
        logic bd;
        db = n_done;
        pulse_start();
        idle_cycles(20);
        pulse_start();
        cyc = 0;
        while (cmos_vsync !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        while (cmos_vsync !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL ign_vsync_timeout got none expected vsync fall"); end
        pulse_start();
        wait_done(100, cyc, bd);
        exp_frames++;
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL ign_done_timeout got none expected frame_done"); end
        idle_cycles(100);
        checks++;
        if (n_done - db != 1) begin errors++; $display("FAIL ign_done_count got %0d expected 1", n_done - db); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL ign_frame_cnt got %0d expected %0d", frame_cnt, exp_frames); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        int wb, cyc;
        logic bd;
        wb = n_wr;
        lb_en = 1'b0;
        pulse_start();
        idle_cycles(70);
        drive_manual_frame(10);
        wait_done(20, cyc, bd);
        exp_frames++;
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL ovf_done_timeout got none expected frame_done"); end
        checks++;
        if (n_wr - wb != 8) begin errors++; $display("FAIL ovf_wr_count got %0d expected 8", n_wr - wb); end
        checks++;
        if (wr_log[wb + 7] !== 32'd75) begin errors++; $display("FAIL ovf_last_wr_addr got %0d expected 75", wr_log[wb + 7]); end
        checks++;
        if ({overflow, size_err} !== 2'b11) begin
            errors++; $display("FAIL ovf_flags got overflow/size_err=%b expected 11", {overflow, size_err});
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL ovf_frame_cnt got %0d expected %0d", frame_cnt, exp_frames); end
        lb_en = 1'b1;
        idle_cycles(10);
    endtask

    task automatic test_reset_mid();
        int db, cyc;
        logic bd;
        pulse_start();
        idle_cycles(20);
        @(negedge clk) rst = 1'b1;
        #1;
        checks++;
        if ({busy, pix_rd_en, cmos_vsync, cmos_href, cmos_clken, wr_en, frame_done, size_err, overflow} !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_flags got %b expected 000000000",
                     {busy, pix_rd_en, cmos_vsync, cmos_href, cmos_clken, wr_en, frame_done, size_err, overflow});
        end
        checks++;
        if (wr_addr !== 32'd54) begin errors++; $display("FAIL rstmid_wr_addr got %0d expected 54", wr_addr); end
        checks++;
        if ({frame_cnt, pix_rd_addr} !== 48'd0) begin
            errors++; $display("FAIL rstmid_counts got frame_cnt=%0d rd_addr=%0d expected 0", frame_cnt, pix_rd_addr);
        end
        idle_cycles(3);
        @(negedge clk) rst = 1'b0;
        exp_frames = 0;
        db = n_done;
        idle_cycles(20);
        checks++;
        if (n_done != db) begin errors++; $display("FAIL rstmid_partial_done got %0d expected 0", n_done - db); end
        pulse_start();
        wait_done(300, cyc, bd);
        exp_frames++;
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL rstmid_done_timeout got none expected frame_done"); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt got %0d expected 1", frame_cnt); end
        checks++;
        if ({size_err, overflow} !== 2'b00) begin
            errors++; $display("FAIL rstmid_flags_after got size_err/overflow=%b expected 00", {size_err, overflow});
        end
    endtask

    task automatic test_drop_clken();
        int wb, cyc;
        logic bd;
        wb = n_wr;
        lb_en = 1'b0;
        pulse_start();
        idle_cycles(70);
        drive_manual_frame(7);
        wait_done(20, cyc, bd);
        exp_frames++;
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL drop_done_timeout got none expected frame_done"); end
        checks++;
        if (n_wr - wb != 7) begin errors++; $display("FAIL drop_wr_count got %0d expected 7", n_wr - wb); end
        checks++;
        if ({size_err, overflow} !== 2'b10) begin
            errors++; $display("FAIL drop_flags got size_err/overflow=%b expected 10", {size_err, overflow});
        end
        lb_en = 1'b1;
        idle_cycles(10);
        wb = n_wr;
        pulse_start();
        wait_done(300, cyc, bd);
        exp_frames++;
        checks++;
        if (cyc < 0) begin errors++; $display("FAIL drop_good_timeout got none expected frame_done"); end
        checks++;
        if (n_wr - wb != 8) begin errors++; $display("FAIL drop_good_wr_count got %0d expected 8", n_wr - wb); end
        checks++;
        if (size_err !== 1'b1) begin errors++; $display("FAIL drop_sticky_size_err got %b expected 1", size_err); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL drop_frame_cnt got %0d expected %0d", frame_cnt, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_start_ignored();
        test_overflow();
        test_reset_mid();
        test_drop_clken();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
